// File: rtl/uart_rec_if.sv
// uart_rec_if: serial line in, received byte out.
// Handshake: data_valid is a one-cycle strobe with no ready/backpressure;
// data is valid in the strobe cycle and held until the next strobe, so the
// consumer must take it in that cycle.
// master = receiver side (drives data/data_valid), slave = line + consumer side.
interface uart_rec_if;
  logic       rx;
  logic [8:0] data;
  logic       data_valid;

  modport master (
    input  rx,
    output data,
    output data_valid
  );

  modport slave (
    output rx,
    input  data,
    input  data_valid
  );
endinterface

// File: rtl/uart_rec.sv
// uart_rec: 8N1 UART receiver, LSB first, idle-high line.
// Oversamples rx with clk, samples each bit at its middle, delivers
// {framing_error, byte} on bus.data with a one-cycle bus.data_valid strobe.
// Optional build macro UART_REC_MAJORITY_EN: every sample becomes the 2-of-3
// majority of rx_s around the sample point (glitch rejection); all sample
// points and the strobe then land one cycle later.
// state_dbg exposes the FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP).
// Clocks per bit must be >= 8.
module uart_rec #(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  uart_rec_if.master bus,
  output logic [1:0] state_dbg
);

  localparam int BIT_CLK  = (CLK_HZ + BITRATE_BPS / 2) / BITRATE_BPS;
  localparam int HALF_CLK = BIT_CLK / 2;
  localparam int CNT_W    = $clog2(BIT_CLK);

`ifdef UART_REC_MAJORITY_EN
  // The +1 tap of the majority window only exists one cycle after the
  // nominal sample point, so the decision is taken then.
  localparam int SAMPLE_LAG = 1;
`else
  localparam int SAMPLE_LAG = 0;
`endif

  localparam logic [CNT_W-1:0] START_LAST    = CNT_W'(HALF_CLK - 1 + SAMPLE_LAG);
  localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(BIT_CLK - 1);
  localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic [7:0]       shreg;
  logic [8:0]       data_q;
  logic             valid_q;
  logic             samp;

`ifdef UART_REC_MAJORITY_EN
  logic rx_d2;

  // Two-flop synchronizer plus history taps for edge detect and majority
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rx_d2   <= 1'b1;
    end else begin
      rx_m    <= bus.rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      rx_d2   <= rx_prev;
    end
  end

  // rx_d2/rx_prev/rx_s are the -1/0/+1 taps when the decision is taken
  assign samp = (rx_s & rx_prev) | (rx_s & rx_d2) | (rx_prev & rx_d2);
`else
  // Two-flop synchronizer plus one history tap for falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= bus.rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign samp = rx_s;
`endif

  // Frame FSM: mid-bit sampling, shift-in, stop check and strobe generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cyc_cnt <= '0;
          bit_idx <= '0;
          // Only a 1->0 transition starts a frame; a line stuck low never does
          if (rx_prev && !rx_s) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cyc_cnt == START_LAST) begin
            cyc_cnt <= '0;
            // High at mid start bit means a glitch, not a frame
            state   <= samp ? S_IDLE : S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt               <= '0;
            shreg[bit_idx[2:0]]   <= samp;
            if (bit_idx == LAST_DATA_IDX) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + CNT_ONE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            // Back to IDLE mid stop bit so a back-to-back start edge is seen
            cyc_cnt <= '0;
            data_q  <= {~samp, shreg};
            valid_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rec.sv
// tb_uart_rec: directed bench for uart_rec at 16 clocks per bit.
// Table of frames checked through an expected-data queue, plus hand-written
// sequences for latency, false start, mid-frame reset and glitches.
module tb_uart_rec;

  localparam int CLK_HZ      = 160;
  localparam int BITRATE_BPS = 10;
  localparam int BIT_CLK     = 16;
  localparam int HALF_CLK    = 8;
`ifdef UART_REC_MAJORITY_EN
  localparam int MAJ_LAG = 1;
`else
  localparam int MAJ_LAG = 0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  uart_rec_if bus ();

  uart_rec #(
    .CLK_HZ      (CLK_HZ),
    .BITRATE_BPS (BITRATE_BPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_front;
  int         checks         = 0;
  int         failures       = 0;
  int         strobes        = 0;
  int         last_valid_cyc = 0;
  int         t_fall         = 0;
  logic       prev_valid     = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      strobes++;
      last_valid_cyc = cycle_no;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_strobe: data=%h, required no strobe", bus.data);
      end else begin
        exp_front = exp_q.pop_front();
        if (bus.data !== exp_front) begin
          failures++;
          $display("FAIL strobe_data: data=%h, required %h", bus.data, exp_front);
        end
      end
      checks++;
      if (prev_valid === 1'b1) begin
        failures++;
        $display("FAIL double_strobe: data_valid high 2 cycles, required 1");
      end
    end
    prev_valid = bus.data_valid;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 * BIT_CLK && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d strobes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < BIT_CLK; c++) begin
      bus.rx = (glitch && c == HALF_CLK) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] dbyte, input logic stop_val,
                            input int idle_bits, input int stop_bits, input logic glitch);
    repeat (idle_bits) drive_bit(1'b1, 1'b0);
    t_fall = cycle_no;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(dbyte[i], glitch);
    repeat (stop_bits) drive_bit(stop_val, 1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] dbyte;
    logic       stop_val;
    int         idle_bits;
    int         stop_bits;
    logic [8:0] exp_data;
  } vec_t;

  localparam int NV = 8;
  vec_t vec[NV];

  logic [7:0] v55;
  int         base;

  initial begin
    vec[0] = '{8'h05, 1'b1, 3, 5, 9'h005};
    vec[1] = '{8'h08, 1'b1, 3, 5, 9'h008};
    vec[2] = '{8'h11, 1'b1, 3, 5, 9'h011};
    vec[3] = '{8'hA1, 1'b1, 0, 1, 9'h0A1};
    vec[4] = '{8'hA3, 1'b1, 0, 1, 9'h0A3};
    vec[5] = '{8'hA5, 1'b1, 0, 1, 9'h0A5};
    vec[6] = '{8'h2B, 1'b0, 1, 6, 9'h12B};
    vec[7] = '{8'h30, 1'b1, 3, 3, 9'h030};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data", int'(bus.data), 9'h000);
    check("reset_valid", int'(bus.data_valid), 0);
    check("reset_state", int'(state_dbg), 0);
    rst = 1'b0;

    // Table: spaced frames, back-to-back frames, stop-low then stuck low
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vec[i].exp_data);
      send_frame(vec[i].dbyte, vec[i].stop_val, vec[i].idle_bits, vec[i].stop_bits, 1'b0);
    end
    wait_drain("table_drain");

    // Start edge on rx to strobe: half bit + 9 bits + 3 sync/register cycles
    exp_q.push_back(9'h05A);
    send_frame(8'h5A, 1'b1, 2, 3, 1'b0);
    wait_drain("latency_drain");
    check("latency_cycles", last_valid_cyc - t_fall, HALF_CLK + 9 * BIT_CLK + 3 + MAJ_LAG);

    // False start: low for a quarter bit only
    base = strobes;
    repeat (HALF_CLK / 2) begin
      bus.rx = 1'b0;
      @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("false_start_state", int'(state_dbg), 0);
    check("false_start_strobes", strobes - base, 0);
    exp_q.push_back(9'h01A);
    send_frame(8'h1A, 1'b1, 2, 3, 1'b0);
    wait_drain("after_false_start_drain");

    // Reset pulse during data bit 4 of 0x55; sender abandons the frame
    base = strobes;
    v55  = 8'h55;
    repeat (3) drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v55[i], 1'b0);
    bus.rx = v55[4];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_data", int'(bus.data), 9'h000);
    check("midreset_valid", int'(bus.data_valid), 0);
    check("midreset_state", int'(state_dbg), 0);
    bus.rx = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("midreset_strobes", strobes - base, 0);
    exp_q.push_back(9'h03C);
    send_frame(8'h3C, 1'b1, 2, 3, 1'b0);
    wait_drain("after_reset_drain");

    // One-cycle high glitch exactly at each data bit's sample point
`ifdef UART_REC_MAJORITY_EN
    exp_q.push_back(9'h000);
`else
    exp_q.push_back(9'h0FF);
`endif
    send_frame(8'h00, 1'b1, 3, 3, 1'b1);
    wait_drain("glitch_drain");

    repeat (2 * BIT_CLK) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rec.md
# uart_rec

Asynchronous serial (UART) receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It oversamples the raw `rx` pin with the system clock, recovers each frame by mid-bit sampling, and presents the byte plus a framing-error flag with a one-cycle valid strobe. It sits directly behind the board RX pin and feeds byte-oriented consumers (FIFO, command parser).

## Interface
- `CLK_HZ`, 66_000_000, system clock frequency in Hz.
- `BITRATE_BPS`, 9_600, line bit rate in bits/s.
- `BIT_CLK` (localparam), CLK_HZ/BITRATE_BPS rounded to nearest integer (6875 at defaults), clocks per bit; must be >= 8.
- `HALF_CLK` (localparam), BIT_CLK/2 (3437 at defaults).

- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  raw asynchronous serial line, idle high.
- `data`  output  9  [7:0] received byte, [8] framing error (stop bit sampled 0).
- `data_valid`  output  1  one-cycle strobe; `data` is valid in that cycle and held until the next strobe.

One clock; reset is synchronous and active-high.

## Operation
- `rx` passes through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: bit counter and cycle counter cleared. A falling edge on `rx_s` (previous 1, current 0) moves to START with cycle counter = 0.
- START: count HALF_CLK cycles, then sample. Sample 0 -> DATA with cycle counter reset. Sample 1 -> false start, back to IDLE, no strobe.
- DATA: every BIT_CLK cycles, sample into shift register bit [bit_idx], LSB first. After 8 samples -> STOP.
- STOP: after BIT_CLK cycles, sample the stop bit. Load `data[7:0]` = shift register and `data[8]` = ~sample. Pulse `data_valid` for one cycle. Return to IDLE.
- A stop-bit-low frame is still delivered, flagged with `data[8]=1`. A new frame then requires a fresh falling edge, so a line stuck low produces no further frames.
- Counters are sized $clog2(BIT_CLK) bits. Cycle counter wraps to 0 at each sample point.
- Reset: FSM to IDLE, counters to 0, `data` = 9'h000, `data_valid` = 0, synchronizer flops = 1. Reset mid-frame aborts the frame with no strobe.

## Timing
- Sample points: start bit at edge + HALF_CLK, data bit k at edge + HALF_CLK + (k+1)*BIT_CLK, stop bit at edge + HALF_CLK + 9*BIT_CLK. Edge time is measured on `rx_s`, which lags `rx` by 2 cycles.
- `data_valid` asserts in the cycle after the stop-bit sample, i.e. about 9.5 bit times + 3 cycles after the start edge on `rx`.
- Back-to-back frames with a single stop bit are supported. IDLE is re-entered mid stop bit, before the next start edge.
- `data_valid` is never high for two consecutive cycles.
- Tolerates about ±4% bit-rate mismatch.

## Configuration
- `UART_REC_MAJORITY_EN` defined: each sample (start, data, stop) is the 2-of-3 majority of `rx_s` at sample point −1, 0 and +1 cycles. This rejects single-cycle glitches. Timing is unchanged except `data_valid` moves 1 cycle later.
- Not defined: single sample at the sample point.

## Test plan
- Default params, frames 0x05, 0x08, 0x11, each as 3 idle bits + start + 8 data + 5 stop bits -> three strobes, `data` = 9'h005, 9'h008, 9'h011 in order.
- Frames 0xA1, 0xA3, 0xA5 back-to-back with 1 stop bit each -> `data` = 9'h0A1, 9'h0A3, 9'h0A5, no missed or extra strobes.
- `rx` low for HALF_CLK/2 cycles then high -> no strobe, FSM back in IDLE, next frame 0x1A received as 9'h01A.
- Frame 0x2B with stop bit driven 0 -> one strobe with `data` = 9'h12B. With `rx` held low afterwards, no further strobe until rx returns high and a new frame 0x30 gives 9'h030.
- `rst` asserted for 1 cycle during data bit 4 of frame 0x55 -> no strobe, `data` = 9'h000, `data_valid` = 0. The following frame 0x3C gives 9'h03C.
- With `UART_REC_MAJORITY_EN`, a single-cycle high glitch at the mid-point of each data bit of frame 0x00 -> `data` = 9'h000.
